// File: rtl/ysyx_22050019_pkg.sv
// Shared ysyx_22050019 definitions: data-memory FSM state encodings and default geometry.
package ysyx_22050019_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [63:0] DMEM_BASE_ADDR = 64'h8000_0000;
  localparam int          DMEM_DEPTH     = 512;

endpackage

// File: rtl/ysyx_22050019_dmem_align.sv
// Byte-lane alignment for the data memory: read right-shift, write mask/data left-shift,
// and detection of write lanes pushed past byte 7.
module ysyx_22050019_dmem_align (
  input  logic [63:0] i_rword,
  input  logic [2:0]  i_roff,
  input  logic [63:0] i_wdata,
  input  logic [7:0]  i_wmask,
  input  logic [2:0]  i_woff,
  output logic [63:0] o_rdata,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wmask,
  output logic        o_overflow
);

  logic [15:0] w_mask_wide;

  // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    o_rdata     = i_rword >> {i_roff, 3'b000};
    o_wdata     = i_wdata << {i_woff, 3'b000};
    w_mask_wide = {8'h00, i_wmask} << i_woff;
    o_wmask     = w_mask_wide[7:0];
    o_overflow  = |w_mask_wide[15:8];
  end

endmodule

// File: rtl/ysyx_22050019_dmem_rsp.sv
// Single-port-style data memory with a fixed-latency request/response handshake
// (IDLE -> WAIT -> RESP), byte-lane alignment and range/boundary error reporting.
module ysyx_22050019_dmem_rsp
  import ysyx_22050019_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int          DEPTH       = DMEM_DEPTH,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_re,
  input  logic [63:0] ram_raddr,
  input  logic        ram_we,
  input  logic [63:0] ram_waddr,
  input  logic [63:0] ram_wdata,
  input  logic [7:0]  wmask,
  output logic [63:0] ram_rdata,
  output logic        rsp_valid,
  output logic        busy,
  output logic        err
);

  localparam int        AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_re, r_we;
  logic [63:0] r_raddr, r_waddr, r_wdata, r_rdata;
  logic [7:0]  r_wmask;
  logic [63:0] r_mem [DEPTH];

  logic        w_accept, w_rsp, w_r_oob, w_w_oob, w_ovf;
  logic [63:0] w_ridx, w_widx, w_rword, w_rdata_al, w_wdata_al, w_rd_now;
  logic [7:0]  w_wmask_al;

  assign w_accept = (r_state == ST_IDLE) && (ram_re || ram_we);
  assign w_rsp    = (r_state == ST_RESP);

  assign w_ridx  = (r_raddr - BASE_ADDR) >> 3;
  assign w_widx  = (r_waddr - BASE_ADDR) >> 3;
  assign w_r_oob = (r_raddr < BASE_ADDR) || (w_ridx >= 64'(DEPTH));
  assign w_w_oob = (r_waddr < BASE_ADDR) || (w_widx >= 64'(DEPTH));
  assign w_rword = w_r_oob ? 64'h0 : r_mem[w_ridx[AW-1:0]];

  ysyx_22050019_dmem_align u_align (
    .i_rword    (w_rword),
    .i_roff     (r_raddr[2:0]),
    .i_wdata    (r_wdata),
    .i_wmask    (r_wmask),
    .i_woff     (r_waddr[2:0]),
    .o_rdata    (w_rdata_al),
    .o_wdata    (w_wdata_al),
    .o_wmask    (w_wmask_al),
    .o_overflow (w_ovf)
  );

  assign w_rd_now = w_r_oob ? 64'h0 : w_rdata_al;

  // Read data is visible during RESP (before the write commits) and then held in r_rdata.
  assign ram_rdata = (w_rsp && r_re) ? w_rd_now : r_rdata;
  assign rsp_valid = w_rsp;
  assign busy      = (r_state != ST_IDLE);
  assign err       = w_rsp && ((r_re && w_r_oob) || (r_we && (w_w_oob || w_ovf)));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (ram_re || ram_we) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept)                                r_cnt <= WAIT_LOAD;
      else if (r_state == ST_WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_raddr <= 64'h0;
      r_waddr <= 64'h0;
      r_wdata <= 64'h0;
      r_wmask <= 8'h00;
      r_rdata <= 64'h0;
    end else begin
      if (w_accept) begin
        r_re    <= ram_re;
        r_we    <= ram_we;
        r_raddr <= ram_raddr;
        r_waddr <= ram_waddr;
        r_wdata <= ram_wdata;
        r_wmask <= wmask;
      end
      if (w_rsp && r_re) r_rdata <= w_rd_now;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_n and an in-flight write is
  // simply never reached because reset forces the FSM out of RESP.
  always_ff @(posedge clk) begin
    if (w_rsp && r_we && !w_w_oob) begin
      for (int b = 0; b < 8; b++) begin
        if (w_wmask_al[b]) r_mem[w_widx[AW-1:0]][8*b +: 8] <= w_wdata_al[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050019_dmem_rsp.sv
// Self-checking bench: two instances (WAIT_CYCLES=1 and 0) driven in lockstep against a
// byte-level reference memory model.
module tb_ysyx_22050019_dmem_rsp;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we;
  logic [63:0] raddr, waddr, wdata;
  logic [7:0]  wm;

  logic [63:0] rdata1, rdata0;
  logic        rsp1, busy1, err1, rsp0, busy0, err0;

  always #5 clk = ~clk;

  ysyx_22050019_dmem_rsp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ram_re(re), .ram_raddr(raddr), .ram_we(we),
    .ram_waddr(waddr), .ram_wdata(wdata), .wmask(wm),
    .ram_rdata(rdata1), .rsp_valid(rsp1), .busy(busy1), .err(err1)
  );

  ysyx_22050019_dmem_rsp #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ram_re(re), .ram_raddr(raddr), .ram_we(we),
    .ram_waddr(waddr), .ram_wdata(wdata), .wmask(wm),
    .ram_rdata(rdata0), .rsp_valid(rsp0), .busy(busy0), .err(err0)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] m [DEPTH];
  logic [63:0] exp_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) / 8) < 64'(DEPTH));
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    if (!in_range(a)) return 64'h0;
    return m[int'((a - BASE) / 8)] >> (8 * int'(a % 8));
  endfunction

  function automatic bit ref_err(input bit r, input logic [63:0] ra, input bit w,
                                 input logic [63:0] wa, input logic [7:0] msk);
    bit e = 1'b0;
    if (r && !in_range(ra)) e = 1'b1;
    if (w) begin
      if (!in_range(wa)) e = 1'b1;
      for (int b = 0; b < 8; b++)
        if (msk[b] && (int'(wa % 8) + b > 7)) e = 1'b1;
    end
    return e;
  endfunction

  task automatic ref_write(input logic [63:0] wa, input logic [63:0] d, input logic [7:0] msk);
    int idx, off;
    if (!in_range(wa)) return;
    idx = int'((wa - BASE) / 8);
    off = int'(wa % 8);
    for (int b = 0; b < 8; b++)
      if (msk[b] && (off + b < 8)) m[idx][8*(off+b) +: 8] = d[8*b +: 8];
  endtask

  // One transaction on both instances; WAIT_CYCLES=0 responds one edge after accept, =1 two edges.
  task automatic do_req(input string tag, input bit r, input logic [63:0] ra, input bit w,
                        input logic [63:0] wa, input logic [63:0] d, input logic [7:0] msk);
    bit e_err;
    e_err = ref_err(r, ra, w, wa, msk);
    if (r) exp_rdata = ref_read(ra);
    @(negedge clk);
    re = r; raddr = ra; we = w; waddr = wa; wdata = d; wm = msk;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
    check({tag, " w0_valid"}, 64'(rsp0), 64'd1);
    check({tag, " w0_err"},   64'(err0), 64'(e_err));
    check({tag, " w0_rdata"}, rdata0, exp_rdata);
    check({tag, " w1_valid_early"}, 64'(rsp1), 64'd0);
    check({tag, " w1_busy"},  64'(busy1), 64'd1);
    @(posedge clk); #1;
    check({tag, " w1_valid"}, 64'(rsp1), 64'd1);
    check({tag, " w1_err"},   64'(err1), 64'(e_err));
    check({tag, " w1_rdata"}, rdata1, exp_rdata);
    check({tag, " w0_idle"},  64'({rsp0, busy0, err0}), 64'd0);
    check({tag, " w0_hold"},  rdata0, exp_rdata);
    if (w) ref_write(wa, d, msk);
    @(posedge clk); #1;
    check({tag, " w1_idle"},  64'({rsp1, busy1, err1}), 64'd0);
  endtask

  task automatic rd(input string tag, input logic [63:0] a);
    do_req(tag, 1'b1, a, 1'b0, 64'h0, 64'h0, 8'h00);
  endtask

  task automatic wr(input string tag, input logic [63:0] a, input logic [63:0] d, input logic [7:0] msk);
    do_req(tag, 1'b0, 64'h0, 1'b1, a, d, msk);
  endtask

  logic [7:0] mask_tab [4];

  initial begin
    mask_tab[0] = 8'h01; mask_tab[1] = 8'h03; mask_tab[2] = 8'h0F; mask_tab[3] = 8'hFF;
    rst_n = 1'b0; re = 1'b0; we = 1'b0; raddr = '0; waddr = '0; wdata = '0; wm = '0;
    exp_rdata = 64'h0;
    #12;
    check("reset_out1", {rdata1[62:0], rsp1}, 64'h0);
    check("reset_flags1", 64'({busy1, err1}), 64'd0);
    check("reset_out0", {rdata0[62:0], rsp0}, 64'h0);
    check("reset_flags0", 64'({busy0, err0}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Give every word known contents so later reads are fully predictable.
    for (int i = 0; i < DEPTH; i++) wr("fill", BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF);

    wr("dw_write", BASE, 64'h1122334455667788, 8'hFF);
    rd("dw_read", BASE);
    check("dw_literal", rdata1, 64'h1122334455667788);

    wr("byte_write", BASE + 64'd3, 64'h0000_0000_0000_00AB, 8'h01);
    rd("byte_read0", BASE);
    check("byte_literal0", rdata1, 64'h11223344AB667788);
    rd("byte_read3", BASE + 64'd3);
    check("byte_literal3", rdata1, 64'h00000011223344AB);

    wr("word_cross", BASE + 64'd6, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
    rd("word_cross_read", BASE);
    check("word_cross_literal", rdata1, 64'hF00D3344AB667788);

    rd("oob_low", BASE - 64'd8);
    rd("oob_high", BASE + 64'(8 * DEPTH));
    wr("oob_wlow", BASE - 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr("oob_whigh", BASE + 64'(8 * DEPTH), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rd("last_word", BASE + 64'(8 * (DEPTH - 1)));
    rd("first_word", BASE);

    do_req("rw_same", 1'b1, BASE + 64'd16, 1'b1, BASE + 64'd16, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rd("rw_follow", BASE + 64'd16);
    check("rw_follow_literal", rdata1, 64'h0123_4567_89AB_CDEF);

    // Reset lands while the WAIT_CYCLES=1 instance is still waiting on a write.
    @(negedge clk);
    we = 1'b1; waddr = BASE + 64'd40; wdata = 64'h5A5A_5A5A_5A5A_5A5A; wm = 8'hFF;
    @(posedge clk); #1;
    we = 1'b0;
    check("rst_pre_busy1", 64'(busy1), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    exp_rdata = 64'h0;
    check("rst_busy", 64'({busy1, busy0}), 64'd0);
    check("rst_valid", 64'({rsp1, rsp0, err1, err0}), 64'd0);
    check("rst_rdata1", rdata1, exp_rdata);
    @(posedge clk); #1;
    check("rst_no_rsp", 64'({rsp1, rsp0}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    rd("rst_dropped", BASE + 64'd40);
    rd("rst_intact", BASE);

    for (int n = 0; n < 300; n++) begin
      logic [63:0] ra, wa;
      bit r, w;
      r  = 1'($urandom);
      w  = r ? 1'($urandom) : 1'b1;
      ra = BASE + 64'($urandom_range(DEPTH * 8 - 1));
      wa = BASE + 64'($urandom_range(DEPTH * 8 - 1));
      if ($urandom_range(7) == 0) ra = BASE + 64'(8 * DEPTH) + 64'($urandom_range(63));
      if ($urandom_range(7) == 0) wa = BASE - 64'(1 + $urandom_range(63));
      do_req("rand", r, ra, w, wa, {$urandom, $urandom}, mask_tab[$urandom_range(3)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
